instr_fetch_unit: RTL

- Fetch stage of the SCC; owns the program counter and drives the instruction-memory read port (i_mem_a, i_mem_en, i_mem_v).
- Delivers fetched words with their PC to decode over a valid/ready handshake.
- Instruction memory read is synchronous: the word for the address issued in cycle N is on i_mem_v in cycle N+1.
- A two-entry output buffer (output register plus skid register) sustains 1 instr/cycle and never drops a returning word under backpressure.

---
 rtl/scc_pkg.sv | 29 ++
 rtl/fetch_skid_buf.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/scc_pkg.sv
// Shared fetch-stage types and constants: state encoding, reset PC and
// instruction-region bounds.
package scc_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] PC_RESET   = 32'h0000_0100;
   localparam logic [ADDR_W-1:0] IMEM_BASE  = 32'h0000_0100;
   localparam int                IMEM_BYTES = 1024;
   localparam logic [ADDR_W-1:0] IMEM_LAST  = IMEM_BASE + 32'(IMEM_BYTES) - 32'd4;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] word;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

   // Word aligned and inside the instruction region.
   function automatic logic pc_is_legal(input logic [ADDR_W-1:0] pc);
      return (pc[1:0] == 2'b00) && (pc >= IMEM_BASE) && (pc <= IMEM_LAST);
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry output buffer (output register + skid register) carrying
// {word, pc} to decode over valid/ready.
module fetch_skid_buf
   import scc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_flush,
   input  logic               i_in_valid,
   input  logic [INSTR_W-1:0] i_in_word,
   input  logic [ADDR_W-1:0]  i_in_pc,
   input  logic               i_out_ready,
   output logic               o_out_valid,
   output logic [INSTR_W-1:0] o_out_word,
   output logic [ADDR_W-1:0]  o_out_pc,
   output logic               o_skid_empty
);

   fetch_entry_t r_out;
   fetch_entry_t r_skid;
   logic         r_out_valid;
   logic         r_skid_valid;
   fetch_entry_t w_in;
   logic         w_out_free;

   assign w_in       = '{word: i_in_word, pc: i_in_pc};
   assign w_out_free = !r_out_valid || i_out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out        <= '0;
         r_skid       <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (i_flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_out_free) begin
         // Skid is older than any arriving word, so it drains first.
         if (r_skid_valid) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= i_in_valid;
            if (i_in_valid) begin
               r_skid <= w_in;
            end
         end else if (i_in_valid) begin
            r_out       <= w_in;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (i_in_valid) begin
         r_skid       <= w_in;
         r_skid_valid <= 1'b1;
      end
   end

   assign o_out_valid  = r_out_valid;
   assign o_out_word   = r_out.word;
   assign o_out_pc     = r_out.pc;
   assign o_skid_empty = !r_skid_valid;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues synchronous instruction-memory reads and
// hands {word, pc} to decode, with redirect and sticky fault handling.
module instr_fetch_unit
   import scc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   output logic [ADDR_W-1:0]  i_mem_a,
   output logic               i_mem_en,
   input  logic [INSTR_W-1:0] i_mem_v,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               inst_ready,
   output logic               inst_valid,
   output logic [INSTR_W-1:0] inst_word,
   output logic [ADDR_W-1:0]  inst_pc,
   output logic               fault,
   output logic [ADDR_W-1:0]  fault_pc
);

   fetch_state_e      r_state;
   fetch_state_e      w_state_next;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_req_pc;
   logic              r_pending;
   logic              r_fault;
   logic [ADDR_W-1:0] r_fault_pc;

   logic w_pc_legal;
   logic w_skid_empty;
   logic w_skid_filling;
   logic w_issue;
   logic w_fault_set;
   logic w_fault_clr;

   assign w_pc_legal = pc_is_legal(r_pc);

   // A returning word that cannot enter the stalled output register takes the
   // skid this cycle, so it is not free for a word issued now.
   assign w_skid_filling = r_pending && inst_valid && !inst_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_fault_set  = 1'b0;
      w_fault_clr  = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_state_next = ST_RUN;
         end
         ST_RUN: begin
            if (!redirect_valid) begin
               if (!w_pc_legal) begin
                  w_state_next = ST_FAULT;
                  w_fault_set  = 1'b1;
               end else begin
                  w_issue = w_skid_empty && !w_skid_filling;
               end
            end
         end
         ST_FAULT: begin
            if (redirect_valid) begin
               if (pc_is_legal(redirect_pc)) begin
                  w_state_next = ST_RUN;
                  w_fault_clr  = 1'b1;
               end
            end else if (!w_pc_legal) begin
               // Refresh the offending PC after a redirect to another bad target.
               w_fault_set = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= PC_RESET;
         r_req_pc   <= '0;
         r_pending  <= 1'b0;
         r_fault    <= 1'b0;
         r_fault_pc <= '0;
      end else begin
         if (redirect_valid) begin
            r_pc      <= redirect_pc;
            r_pending <= 1'b0;
         end else begin
            r_pending <= w_issue;
            if (w_issue) begin
               r_req_pc <= r_pc;
               r_pc     <= r_pc + 32'd4;
            end
         end
         if (w_fault_set) begin
            r_fault    <= 1'b1;
            r_fault_pc <= r_pc;
         end else if (w_fault_clr) begin
            r_fault <= 1'b0;
         end
      end
   end

   fetch_skid_buf u_skid_buf (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (redirect_valid),
      .i_in_valid   (r_pending),
      .i_in_word    (i_mem_v),
      .i_in_pc      (r_req_pc),
      .i_out_ready  (inst_ready),
      .o_out_valid  (inst_valid),
      .o_out_word   (inst_word),
      .o_out_pc     (inst_pc),
      .o_skid_empty (w_skid_empty)
   );

   assign i_mem_a  = r_pc;
   assign i_mem_en = w_issue;
   assign fault    = r_fault;
   assign fault_pc = r_fault_pc;

endmodule
